// File: rtl/fifo_uart_tx.sv
// rtl/fifo_uart_tx.sv - drains a byte FIFO onto an 8N1 UART line, LSB first
`timescale 1ns/1ps
module fifo_uart_tx #(
   parameter int CLKS_PER_BIT = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       tx_enable,
   input  logic       fifo_empty,
   input  logic [7:0] fifo_data,
   output logic       fifo_rd_en,
   output logic       tx,
   output logic       busy,
   output logic [7:0] frames_sent
);

   localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

   typedef enum logic [2:0] {IDLE, POP, LOAD, START, DATA, STOP} state_t;

   state_t        state, state_nx;
   logic [BW-1:0] baud_cnt, baud_nx;
   logic [2:0]    bit_idx, bit_nx;
   logic [7:0]    shift, shift_nx;
   logic [7:0]    frames_nx;
   logic          tx_nx;
   logic          bit_done;

   assign bit_done   = (baud_cnt == BAUD_LAST);
   assign fifo_rd_en = (state == POP);
   assign busy       = (state != IDLE);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= IDLE;
         baud_cnt    <= '0;
         bit_idx     <= '0;
         shift       <= '0;
         tx          <= 1'b1;
         frames_sent <= '0;
      end else begin
         state       <= state_nx;
         baud_cnt    <= baud_nx;
         bit_idx     <= bit_nx;
         shift       <= shift_nx;
         tx          <= tx_nx;
         frames_sent <= frames_nx;
      end
   end

   always_comb begin
      state_nx  = state;
      baud_nx   = baud_cnt + BW'(1);
      bit_nx    = bit_idx;
      shift_nx  = shift;
      frames_nx = frames_sent;
      case (state)
         IDLE: begin
            baud_nx = '0;
            if (tx_enable && !fifo_empty) state_nx = POP;
         end
         POP: begin
            baud_nx  = '0;
            state_nx = LOAD;
         end
         LOAD: begin
            // FIFO output is registered, so the popped byte is valid here
            baud_nx  = '0;
            shift_nx = fifo_data;
            state_nx = START;
         end
         START: begin
            if (bit_done) begin
               baud_nx  = '0;
               bit_nx   = '0;
               state_nx = DATA;
            end
         end
         DATA: begin
            if (bit_done) begin
               baud_nx  = '0;
               shift_nx = shift >> 1;
               bit_nx   = bit_idx + 3'd1;
               if (bit_idx == 3'd7) state_nx = STOP;
            end
         end
         STOP: begin
            if (bit_done) begin
               baud_nx   = '0;
               frames_nx = frames_sent + 8'd1;
               state_nx  = IDLE;
            end
         end
         default: begin
            baud_nx  = '0;
            state_nx = IDLE;
         end
      endcase

      // tx is a register driven from the next state, so the line never glitches
      case (state_nx)
         START:   tx_nx = 1'b0;
         DATA:    tx_nx = shift_nx[0];
         default: tx_nx = 1'b1;
      endcase
   end

endmodule
